// File: rtl/obstacle_pkg.sv
// Shared types and constants for the obstacle sprite core: motion states,
// sprite geometry, coordinate width and the default colour palette.
package obstacle_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE      = 2'd1,
    OFFSCREEN = 2'd2
  } motion_state_t;

  localparam int SPR_W   = 32;
  localparam int SPR_H   = 32;
  localparam int COORD_W = 12;

  localparam logic [11:0] PAL_COLOR1 = 12'hF00;
  localparam logic [11:0] PAL_COLOR2 = 12'h0F0;
  localparam logic [11:0] PAL_COLOR3 = 12'hFFF;

  // Code 0 is the transparent key and maps to black.
  function automatic logic [11:0] code_to_rgb(input logic [1:0]  code,
                                              input logic [11:0] c1,
                                              input logic [11:0] c2,
                                              input logic [11:0] c3);
    logic [11:0] res;
    res = 12'h000;
    case (code)
      2'd1:    res = c1;
      2'd2:    res = c2;
      2'd3:    res = c3;
      default: res = 12'h000;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/obstacle_sprite_core_if.sv
// Read port between the obstacle core and the external sprite RAM.
interface obstacle_sprite_core_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 2
);
  logic [ADDR_WIDTH-1:0] ram_addr_r;
  logic [DATA_WIDTH-1:0] ram_dout;

  modport master (output ram_addr_r, input  ram_dout);
  modport slave  (input  ram_addr_r, output ram_dout);
endinterface

// File: rtl/obstacle_motion_fsm.sv
// Horizontal motion of the obstacle: per-frame scrolling, off-screen wait and respawn.
//   state     | meaning
//   IDLE      | parked at H_RES, waiting for a frame_tick with run=1
//   MOVE      | x_pos drops by speed on each frame_tick while run=1
//   OFFSCREEN | counting down frames before respawning at H_RES
module obstacle_motion_fsm
  import obstacle_pkg::*;
#(
  parameter int H_RES          = 640,
  parameter int RESPAWN_FRAMES = 60
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      frame_tick,
  input  logic                      run,
  input  logic                      clear,
  input  logic [3:0]                speed,
  output logic signed [COORD_W-1:0] x_pos,
  output logic                      wrap_pulse
);

  localparam int CNT_W = (RESPAWN_FRAMES > 1) ? $clog2(RESPAWN_FRAMES) : 1;
  localparam logic signed [COORD_W-1:0] X_SPAWN = COORD_W'(H_RES);
  localparam logic signed [COORD_W-1:0] X_GONE  = COORD_W'(-SPR_W);

  motion_state_t            state;
  logic [CNT_W-1:0]         frame_cnt;
  logic signed [COORD_W-1:0] x_next;

  assign x_next = x_pos - $signed({{(COORD_W-4){1'b0}}, speed});

  // Position only ever changes on frame_tick (or clear), so a frame is never torn.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      x_pos      <= X_SPAWN;
      frame_cnt  <= '0;
      wrap_pulse <= 1'b0;
    end else begin
      wrap_pulse <= 1'b0;
      if (clear) begin
        state     <= IDLE;
        x_pos     <= X_SPAWN;
        frame_cnt <= '0;
      end else if (frame_tick) begin
        case (state)
          IDLE: begin
            if (run) state <= MOVE;
          end
          MOVE: begin
            if (run) begin
              x_pos <= x_next;
              if (x_next <= X_GONE) begin
                state      <= OFFSCREEN;
                wrap_pulse <= 1'b1;
                frame_cnt  <= CNT_W'(RESPAWN_FRAMES - 1);
              end
            end
          end
          OFFSCREEN: begin
            if (frame_cnt == '0) begin
              x_pos <= X_SPAWN;
              state <= MOVE;
            end else begin
              frame_cnt <= frame_cnt - CNT_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/obstacle_sprite_core.sv
// Obstacle sprite renderer: maps the scan position into the 32x32 sprite RAM,
// aligns with the RAM read latency and applies the palette.
module obstacle_sprite_core
  import obstacle_pkg::*;
#(
  parameter int          ADDR_WIDTH     = 10,
  parameter int          DATA_WIDTH     = 2,
  parameter int          H_RES          = 640,
  parameter int          RESPAWN_FRAMES = 60,
  parameter logic [11:0] COLOR1         = PAL_COLOR1,
  parameter logic [11:0] COLOR2         = PAL_COLOR2,
  parameter logic [11:0] COLOR3         = PAL_COLOR3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [10:0]               x,
  input  logic [10:0]               y,
  input  logic                      frame_tick,
  input  logic                      run,
  input  logic                      clear,
  input  logic [3:0]                speed,
  input  logic [10:0]               y_pos,
  obstacle_sprite_core_if.master    ram,
  output logic [11:0]               rgb,
  output logic                      visible,
  output logic signed [COORD_W-1:0] x_pos,
  output logic                      wrap_pulse
);

  localparam logic signed [COORD_W-1:0] SPR_W_C = COORD_W'(SPR_W);
  localparam logic signed [COORD_W-1:0] SPR_H_C = COORD_W'(SPR_H);

  logic signed [COORD_W-1:0] col;
  logic signed [COORD_W-1:0] row;
  logic                      in_region;
  logic                      in_region_d;
  logic [DATA_WIDTH-1:0]     pix_code;

  obstacle_motion_fsm #(
    .H_RES          (H_RES),
    .RESPAWN_FRAMES (RESPAWN_FRAMES)
  ) u_motion (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .run        (run),
    .clear      (clear),
    .speed      (speed),
    .x_pos      (x_pos),
    .wrap_pulse (wrap_pulse)
  );

  assign col = $signed({1'b0, x}) - x_pos;
  assign row = $signed({1'b0, y}) - $signed({1'b0, y_pos});

  // Sign-bit tests instead of >= 0 keep the compare signed; this also clips a
  // sprite hanging off the left edge without wrapping the address.
  assign in_region = !col[COORD_W-1] && (col < SPR_W_C) &&
                     !row[COORD_W-1] && (row < SPR_H_C);

  assign ram.ram_addr_r = in_region ? ADDR_WIDTH'({row[4:0], col[4:0]}) : '0;
  assign pix_code       = ram.ram_dout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_region_d <= 1'b0;
      rgb         <= 12'h000;
      visible     <= 1'b0;
    end else begin
      in_region_d <= in_region;
      if (in_region_d && (pix_code != '0)) begin
        visible <= 1'b1;
        rgb     <= code_to_rgb(2'(pix_code), COLOR1, COLOR2, COLOR3);
      end else begin
        visible <= 1'b0;
        rgb     <= 12'h000;
      end
    end
  end

endmodule

// File: tb/tb_obstacle_sprite_core.sv
// Bench for obstacle_sprite_core: directed and random motion and pixel scenarios
// against a frame-level position model and a pixel-level lookup model.
module tb_obstacle_sprite_core;

  localparam int H  = 640;
  localparam int RF = 3;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [10:0]        x = '0, y = '0, y_pos = '0;
  logic               frame_tick = 1'b0, run = 1'b0, clear = 1'b0;
  logic [3:0]         speed = '0;
  logic [11:0]        rgb;
  logic               visible;
  logic signed [11:0] x_pos;
  logic               wrap_pulse;

  obstacle_sprite_core_if #(.ADDR_WIDTH(10), .DATA_WIDTH(2)) ram_if ();

  obstacle_sprite_core #(.RESPAWN_FRAMES(RF)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .x          (x),
    .y          (y),
    .frame_tick (frame_tick),
    .run        (run),
    .clear      (clear),
    .speed      (speed),
    .y_pos      (y_pos),
    .ram        (ram_if),
    .rgb        (rgb),
    .visible    (visible),
    .x_pos      (x_pos),
    .wrap_pulse (wrap_pulse)
  );

  logic [1:0] mem [1024];
  always @(posedge clk) ram_if.ram_dout <= mem[ram_if.ram_addr_r];

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Frame-level model: 0 parked, 1 scrolling, 2 waiting off-screen
  int m_mode, m_xp, m_cnt;
  bit m_wrap;

  function automatic logic [11:0] pal(input int code);
    case (code)
      1:       return 12'hF00;
      2:       return 12'h0F0;
      3:       return 12'hFFF;
      default: return 12'h000;
    endcase
  endfunction

  function automatic bit in_sprite(input int px, input int py, input int xp, input int yp);
    return (px - xp >= 0) && (px - xp < 32) && (py - yp >= 0) && (py - yp < 32);
  endfunction

  function automatic int sprite_addr(input int px, input int py, input int xp, input int yp);
    if (!in_sprite(px, py, xp, yp)) return 0;
    return (py - yp) * 32 + (px - xp);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_xp = H; m_cnt = 0; m_wrap = 1'b0;
  endtask

  // Drive one clock of control inputs and advance the model accordingly.
  task automatic step(input bit ft, input bit r, input int spd, input bit clr);
    frame_tick = ft; run = r; speed = 4'(spd); clear = clr;
    @(posedge clk); #1;
    frame_tick = 1'b0; clear = 1'b0;
    m_wrap = 1'b0;
    if (clr) begin
      m_mode = 0; m_xp = H; m_cnt = 0;
    end else if (ft) begin
      if (m_mode == 0) begin
        if (r) m_mode = 1;
      end else if (m_mode == 1) begin
        if (r) begin
          m_xp = m_xp - spd;
          if (m_xp <= -32) begin
            m_mode = 2; m_wrap = 1'b1; m_cnt = RF - 1;
          end
        end
      end else begin
        if (m_cnt == 0) begin
          m_xp = H; m_mode = 1;
        end else begin
          m_cnt = m_cnt - 1;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total++; if (x_pos !== 12'sd640) begin bad++; $display("FAIL reset_x_pos got=%0d want=640", x_pos); end
    total++; if (wrap_pulse !== 1'b0) begin bad++; $display("FAIL reset_wrap got=%b want=0", wrap_pulse); end
    total++; if (rgb !== 12'h000) begin bad++; $display("FAIL reset_rgb got=%h want=000", rgb); end
    total++; if (visible !== 1'b0) begin bad++; $display("FAIL reset_visible got=%b want=0", visible); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    model_reset();
  endtask

  task automatic test_motion_wrap();
    step(1, 1, 8, 0);
    total++; if (x_pos !== 12'sd640) begin bad++; $display("FAIL start_move got=%0d want=640", x_pos); end
    for (int i = 1; i <= 84; i++) begin
      step(1, 1, 8, 0);
      total++; if (x_pos !== 12'(640 - 8 * i)) begin bad++; $display("FAIL move_seq[%0d] got=%0d want=%0d", i, x_pos, 640 - 8 * i); end
      total++; if (wrap_pulse !== (i == 84)) begin bad++; $display("FAIL wrap_at[%0d] got=%b want=%b", i, wrap_pulse, i == 84); end
    end
    step(0, 1, 8, 0);
    total++; if (wrap_pulse !== 1'b0) begin bad++; $display("FAIL wrap_width got=%b want=0", wrap_pulse); end
    total++; if (x_pos !== -12'sd32) begin bad++; $display("FAIL wrap_pos got=%0d want=-32", x_pos); end
    for (int i = 1; i <= 3; i++) begin
      step(1, 0, 8, 0);
      total++; if (x_pos !== ((i < 3) ? -12'sd32 : 12'sd640)) begin bad++; $display("FAIL respawn[%0d] got=%0d", i, x_pos); end
    end
    step(1, 1, 8, 0);
    total++; if (x_pos !== 12'sd632) begin bad++; $display("FAIL after_respawn got=%0d want=632", x_pos); end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 4; i++) begin
      step(1, 0, $urandom_range(1, 15), 0);
      total++; if (x_pos !== 12'sd632) begin bad++; $display("FAIL run0_hold[%0d] got=%0d want=632", i, x_pos); end
    end
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 0, 0);
      total++; if (x_pos !== 12'sd632 || wrap_pulse !== 1'b0) begin bad++; $display("FAIL speed0_hold[%0d] got=%0d/%b want=632/0", i, x_pos, wrap_pulse); end
    end
    for (int i = 0; i < 6; i++) begin
      step(0, 1, $urandom_range(1, 15), 0);
      total++; if (x_pos !== 12'sd632) begin bad++; $display("FAIL no_tick_hold[%0d] got=%0d want=632", i, x_pos); end
    end
  endtask

  task automatic test_clear();
    step(1, 1, 5, 1);
    total++; if (x_pos !== 12'sd640) begin bad++; $display("FAIL clear_tick got=%0d want=640", x_pos); end
    step(1, 1, 5, 0);
    total++; if (x_pos !== 12'sd640) begin bad++; $display("FAIL clear_idle got=%0d want=640", x_pos); end
    step(1, 1, 5, 0);
    total++; if (x_pos !== 12'sd635) begin bad++; $display("FAIL clear_resume got=%0d want=635", x_pos); end
    step(0, 1, 5, 1);
    total++; if (x_pos !== 12'sd640) begin bad++; $display("FAIL clear_notick got=%0d want=640", x_pos); end
    step(1, 1, 5, 0);
    total++; if (x_pos !== 12'(m_xp)) begin bad++; $display("FAIL clear_reenter got=%0d want=%0d", x_pos, m_xp); end
  endtask

  task automatic test_latency();
    y_pos = 11'd200;
    for (int i = 0; i < 54; i++) step(1, 1, 10, 0);
    total++; if (x_pos !== 12'sd100) begin bad++; $display("FAIL reach_100 got=%0d want=100", x_pos); end
    mem[0] = 2'b01; mem[33] = 2'b00;
    x = 11'd0; y = 11'd0;
    @(posedge clk); #1; @(posedge clk); #1;
    x = 11'd100; y = 11'd200; #1;
    total++; if (ram_if.ram_addr_r !== 10'd0) begin bad++; $display("FAIL lat_addr got=%0d want=0", ram_if.ram_addr_r); end
    @(posedge clk); #1;
    total++; if (visible !== 1'b0) begin bad++; $display("FAIL lat_early got=%b want=0", visible); end
    x = 11'd101; y = 11'd201; #1;
    total++; if (ram_if.ram_addr_r !== 10'd33) begin bad++; $display("FAIL addr33 got=%0d want=33", ram_if.ram_addr_r); end
    @(posedge clk); #1;
    total++; if (rgb !== 12'hF00 || visible !== 1'b1) begin bad++; $display("FAIL lat_pixel got=%h/%b want=F00/1", rgb, visible); end
    x = 11'd132; y = 11'd200; #1;
    total++; if (ram_if.ram_addr_r !== 10'd0) begin bad++; $display("FAIL outside_addr got=%0d want=0", ram_if.ram_addr_r); end
    @(posedge clk); #1;
    total++; if (rgb !== 12'h000 || visible !== 1'b0) begin bad++; $display("FAIL transparent got=%h/%b want=000/0", rgb, visible); end
    @(posedge clk); #1;
    total++; if (visible !== 1'b0) begin bad++; $display("FAIL outside_vis got=%b want=0", visible); end
  endtask

  task automatic test_random_pixels(input int n);
    logic [11:0] q_rgb[$];
    bit          q_vis[$];
    int px, py, yp, a;
    bit in;
    yp = $urandom_range(0, 400);
    y_pos = 11'(yp);
    for (int i = 0; i < n; i++) begin
      px = m_xp - 8 + $urandom_range(0, 47);
      if (px < 0) px = $urandom_range(0, 40);
      py = yp - 8 + $urandom_range(0, 47);
      if (py < 0) py = $urandom_range(0, 40);
      x = 11'(px); y = 11'(py);
      in = in_sprite(px, py, m_xp, yp);
      a  = sprite_addr(px, py, m_xp, yp);
      q_rgb.push_back(in ? pal(int'(mem[a])) : 12'h000);
      q_vis.push_back(in && (mem[a] != 2'b00));
      #1;
      total++; if (ram_if.ram_addr_r !== 10'(a)) begin bad++; $display("FAIL rnd_addr[%0d] got=%0d want=%0d", i, ram_if.ram_addr_r, a); end
      if (q_rgb.size() > 2) begin
        logic [11:0] er;
        bit ev;
        er = q_rgb.pop_front();
        ev = q_vis.pop_front();
        total++; if (rgb !== er || visible !== ev) begin bad++; $display("FAIL rnd_pix[%0d] got=%h/%b want=%h/%b", i, rgb, visible, er, ev); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_edge_clip();
    int tx[6] = '{0, 21, 22, 0, 0, 5};
    int ty[6] = '{200, 200, 200, 231, 232, 199};
    int ta[6] = '{10, 31, 0, 1002, 0, 0};
    y_pos = 11'd200;
    for (int i = 0; i < 11; i++) step(1, 1, 10, 0);
    total++; if (x_pos !== -12'sd10) begin bad++; $display("FAIL reach_m10 got=%0d want=-10", x_pos); end
    for (int i = 0; i < 6; i++) begin
      x = 11'(tx[i]); y = 11'(ty[i]); #1;
      total++; if (ram_if.ram_addr_r !== 10'(ta[i])) begin bad++; $display("FAIL clip_addr[%0d] got=%0d want=%0d", i, ram_if.ram_addr_r, ta[i]); end
      @(posedge clk); #1;
    end
    mem[10] = 2'b11;
    x = 11'd0; y = 11'd200;
    @(posedge clk); #1; @(posedge clk); #1;
    total++; if (rgb !== 12'hFFF || visible !== 1'b1) begin bad++; $display("FAIL clip_pixel got=%h/%b want=FFF/1", rgb, visible); end
  endtask

  task automatic test_reset_async();
    bit hit;
    #2; rst_n = 1'b0; #1;
    total++; if (visible !== 1'b0 || rgb !== 12'h000) begin bad++; $display("FAIL rst_move_pix got=%h/%b want=000/0", rgb, visible); end
    total++; if (x_pos !== 12'sd640) begin bad++; $display("FAIL rst_move_x got=%0d want=640", x_pos); end
    @(negedge clk); rst_n = 1'b1;
    model_reset();
    x = 11'd0; y = 11'd0;
    step(1, 1, 15, 0);
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      step(1, 1, 15, 0);
      hit = m_wrap;
    end
    total++; if (!hit) begin bad++; $display("FAIL wrap_timeout got=no_wrap want=wrap"); end
    total++; if (wrap_pulse !== 1'b1 || x_pos !== -12'sd35) begin bad++; $display("FAIL wrap15 got=%b/%0d want=1/-35", wrap_pulse, x_pos); end
    #2; rst_n = 1'b0; #1;
    total++; if (x_pos !== 12'sd640 || wrap_pulse !== 1'b0) begin bad++; $display("FAIL rst_off got=%0d/%b want=640/0", x_pos, wrap_pulse); end
    total++; if (rgb !== 12'h000 || visible !== 1'b0) begin bad++; $display("FAIL rst_off_pix got=%h/%b want=000/0", rgb, visible); end
    @(negedge clk); rst_n = 1'b1;
    model_reset();
    step(1, 1, 4, 0);
    total++; if (x_pos !== 12'sd640) begin bad++; $display("FAIL post_rst_idle got=%0d want=640", x_pos); end
    step(1, 1, 4, 0);
    total++; if (x_pos !== 12'sd636) begin bad++; $display("FAIL post_rst_move got=%0d want=636", x_pos); end
  endtask

  task automatic test_random_motion(input int n);
    bit ft, r, clr;
    int spd;
    for (int i = 0; i < n; i++) begin
      ft  = ($urandom_range(0, 3) != 0);
      r   = ($urandom_range(0, 3) != 0);
      spd = $urandom_range(0, 15);
      clr = ($urandom_range(0, 39) == 0);
      step(ft, r, spd, clr);
      total++; if (x_pos !== 12'(m_xp) || wrap_pulse !== m_wrap) begin bad++; $display("FAIL rnd_motion[%0d] got=%0d/%b want=%0d/%b", i, x_pos, wrap_pulse, m_xp, m_wrap); end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 2'($urandom);
    model_reset();
    test_reset();
    test_motion_wrap();
    test_hold();
    test_clear();
    test_latency();
    test_random_pixels(150);
    test_edge_clip();
    test_reset_async();
    test_random_motion(300);
    test_random_pixels(150);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/obstacle_sprite_core.md
OBSTACLE_SPRITE_CORE -- requirements
Module: obstacle_sprite_core

Interface
REQ-001 Parameters SHALL be, as name, default, meaning:
- ADDR_WIDTH, 10, sprite RAM address width (32x32 sprite).
- DATA_WIDTH, 2, pixel code width.
- H_RES, 640, x coordinate of the off-screen spawn point.
- RESPAWN_FRAMES, 60, frames spent off-screen before respawn.
- COLOR1/COLOR2/COLOR3, 12'hF00/12'h0F0/12'hFFF, 12-bit RGB colours for codes 1..3.
REQ-002 Clocking: one clock; reset is asynchronous and active-low. Ports, as name, direction, width, meaning:
- clk  in  1  system/pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- x  in  11  current pixel column.
- y  in  11  current pixel row.
- frame_tick  in  1  one-cycle pulse once per frame, during vblank.
- run  in  1  motion enable.
- clear  in  1  synchronous return to IDLE.
- speed  in  4  pixels moved per frame.
- y_pos  in  11  obstacle top row.
- ram_addr_r  out  ADDR_WIDTH  read address to the sprite RAM.
- ram_dout  in  DATA_WIDTH  sprite RAM read data, valid one clk after ram_addr_r.
- rgb  out  12  pixel colour.
- visible  out  1  high when rgb is an opaque obstacle pixel.
- x_pos  out  12  signed obstacle left edge.
- wrap_pulse  out  1  one-cycle pulse when the obstacle leaves the screen.

Function
REQ-003 Arithmetic SHALL be 12-bit signed: col = x - x_pos, row = y - y_pos.
REQ-004 The pixel is in-region iff 0 <= col < 32 and 0 <= row < 32.
REQ-005 ram_addr_r SHALL be combinational: {row[4:0], col[4:0]} when in-region, otherwise 0.
REQ-006 The in-region flag SHALL be delayed one cycle so that it aligns with ram_dout.
REQ-007 Palette: code 0 is transparent (visible=0, rgb=0); codes 1/2/3 map to COLOR1/COLOR2/COLOR3 with visible=1.
REQ-008 rgb and visible SHALL be registered, for a total latency of 2 clk from x/y to rgb/visible.
REQ-009 The motion FSM SHALL have states IDLE, MOVE and OFFSCREEN.
REQ-010 IDLE: x_pos=H_RES; goes to MOVE on the first frame_tick with run=1.
REQ-011 MOVE: on each frame_tick with run=1, x_pos <= x_pos - speed; with run=0, x_pos holds.
REQ-012 MOVE: when the updated x_pos <= -32, the FSM SHALL go to OFFSCREEN, assert wrap_pulse for one clk, and load the frame counter with RESPAWN_FRAMES-1.
REQ-013 OFFSCREEN: the counter decrements on each frame_tick, independent of run; on the frame_tick with counter=0, x_pos <= H_RES and the FSM goes to MOVE.
REQ-014 x_pos SHALL change only on frame_tick cycles, so there is no mid-frame tearing.
REQ-015 clear=1 forces IDLE and x_pos=H_RES on the next clk edge, and has priority over a simultaneous frame_tick.
REQ-016 speed=0 SHALL hold the position with no wrap.
REQ-017 speed values SHALL be sampled only on frame_tick.
REQ-018 A pixel straddling the left edge (x_pos negative) SHALL render only its in-range columns, with no address wrap.

Reset
REQ-019 rst_n low SHALL asynchronously set: FSM=IDLE, x_pos=H_RES, counter=0, rgb=0, visible=0, wrap_pulse=0, delayed in-region flag=0.
REQ-020 Reset mid-MOVE or mid-OFFSCREEN SHALL abandon the motion; operation resumes per REQ-010 after release.

Structure
REQ-021 The package obstacle_pkg SHALL hold:
- the state enum (IDLE/MOVE/OFFSCREEN);
- SPR_W=32, SPR_H=32;
- COORD_W=12;
- the palette constants.
REQ-022 The FSM, frame counter and x_pos SHALL live in sub-module obstacle_motion_fsm.
REQ-023 Addressing, alignment and palette logic SHALL live in the top level.
REQ-024 The sprite RAM SHALL be instantiated outside this block.

Verification
REQ-025 Latency check:
- Stimulus: x_pos=100, y_pos=200, RAM word 0 = 2'b01, drive x=100, y=200.
- Required: ram_addr_r=0 the same cycle; rgb=12'hF00 and visible=1 exactly 2 clk later.
REQ-026 Transparency and region:
- Stimulus 1: code 0 at address 33, pixel (101,201) → required: visible=0, rgb=0.
- Stimulus 2: pixel (132,200) → required: ram_addr_r=0, visible=0.
REQ-027 Motion and wrap:
- Stimulus: run=1, speed=8, frame_ticks from IDLE.
- Required: x_pos sequence 640, 632, 624, ...
- Required: after 84 moves, x_pos=-32, the FSM enters OFFSCREEN and wrap_pulse is a single clk.
REQ-028 Respawn:
- Stimulus: RESPAWN_FRAMES=3.
- Required: after 3 further frame_ticks, x_pos=640 and the FSM is in MOVE.
- Stimulus: run=0 during MOVE → required: x_pos frozen.
REQ-029 Edge clipping:
- Stimulus: x_pos=-10, x=0, y=y_pos.
- Required: ram_addr_r=10.
REQ-030 Clear and reset priority:
- Stimulus: clear and frame_tick in the same cycle → required: IDLE, x_pos=640.
- Stimulus: rst_n low asynchronously mid-OFFSCREEN → required: all outputs at reset values immediately.
